// File: rtl/sync_fifo_param.sv
// Single-clock first-word-fall-through FIFO with occupancy count, watermarks and error pulses.
// Latency: a write reaches data_out one cycle after its edge; flags and count move on that same edge.
// Backpressure: full/empty gate the accepted write/read; rejected requests only raise overflow/underflow.
//
// Ports:
//   clk, rst_n            - clock (rising edge) and asynchronous active-low reset
//   write, data_in        - write request and write data; ignored while full
//   read                  - pop the head entry; ignored while empty
//   data_out              - head entry, valid whenever empty is low
//   full, almost_full     - count == DEPTH, count >= P_AFULL_THRESH
//   empty, almost_empty   - count == 0, count <= P_AEMPTY_THRESH
//   count                 - occupancy 0..DEPTH
//   overflow, underflow   - one-cycle pulses after a rejected write/read
module sync_fifo_param #(
    parameter int P_DATA_WIDTH    = 32,
    parameter int P_ADDR_WIDTH    = 4,
    parameter int P_AFULL_THRESH  = 2**P_ADDR_WIDTH - 2,
    parameter int P_AEMPTY_THRESH = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    write,
    input  logic [P_DATA_WIDTH-1:0] data_in,
    output logic                    full,
    output logic                    almost_full,
    input  logic                    read,
    output logic [P_DATA_WIDTH-1:0] data_out,
    output logic                    empty,
    output logic                    almost_empty,
    output logic [P_ADDR_WIDTH:0]   count,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int DEPTH = 2**P_ADDR_WIDTH;
    localparam int CW    = P_ADDR_WIDTH + 1;

    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C  = CW'(P_AFULL_THRESH);
    localparam logic [CW-1:0] AEMPTY_C = CW'(P_AEMPTY_THRESH);
    localparam logic [CW-1:0] ONE_C    = CW'(1);

    // Storage is deliberately unreset so it maps onto distributed RAM.
    logic [P_DATA_WIDTH-1:0] mem [DEPTH];

    // Pointers carry one extra wrap bit; only the low bits address the RAM.
    logic [CW-1:0] wptr;
    logic [CW-1:0] rptr;
    logic [CW-1:0] count_next;
    logic          wr_en;
    logic          rd_en;

    // Acceptance uses the registered flags, i.e. the state before the edge.
    // A write while full is rejected even if a read frees a slot this cycle.
    assign wr_en = write && !full;
    assign rd_en = read && !empty;

    always_comb begin
        count_next = count;
        case ({wr_en, rd_en})
            2'b10:   count_next = count + ONE_C;
            2'b01:   count_next = count - ONE_C;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr         <= '0;
            rptr         <= '0;
            count        <= '0;
            full         <= 1'b0;
            almost_full  <= 1'b0;
            empty        <= 1'b1;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (wr_en) begin
                wptr <= wptr + ONE_C;
            end
            if (rd_en) begin
                rptr <= rptr + ONE_C;
            end
            count <= count_next;
            // Flags are derived from count_next so they settle on the same
            // edge as count rather than one cycle behind it.
            full         <= (count_next == DEPTH_C);
            empty        <= (count_next == '0);
            almost_full  <= (count_next >= AFULL_C);
            almost_empty <= (count_next <= AEMPTY_C);
            overflow     <= write && full;
            underflow    <= read && empty;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wptr[P_ADDR_WIDTH-1:0]] <= data_in;
        end
    end

    // Combinational read gives first-word-fall-through behaviour.
    assign data_out = mem[rptr[P_ADDR_WIDTH-1:0]];

endmodule

// File: tb/tb_sync_fifo_param.sv
module tb_sync_fifo_param;

    localparam int DW     = 32;
    localparam int AW     = 4;
    localparam int DEPTH  = 16;
    localparam int AF_TH  = 14;
    localparam int AE_TH  = 1;

    logic          clk;
    logic          rst_n;
    logic          write;
    logic [DW-1:0] data_in;
    logic          full;
    logic          almost_full;
    logic          read;
    logic [DW-1:0] data_out;
    logic          empty;
    logic          almost_empty;
    logic [AW:0]   count;
    logic          overflow;
    logic          underflow;

    int checks = 0;
    int errors = 0;

    // Reference model: contents of the FIFO, head at index 0.
    logic [DW-1:0] model_q[$];
    // Scoreboard: data expected on each accepted read, in order.
    logic [DW-1:0] sb_q[$];

    sync_fifo_param #(
        .P_DATA_WIDTH   (DW),
        .P_ADDR_WIDTH   (AW),
        .P_AFULL_THRESH (AF_TH),
        .P_AEMPTY_THRESH(AE_TH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .write       (write),
        .data_in     (data_in),
        .full        (full),
        .almost_full (almost_full),
        .read        (read),
        .data_out    (data_out),
        .empty       (empty),
        .almost_empty(almost_empty),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: whenever the DUT is about to pop its head, compare it with
    // the next scoreboard entry.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && read === 1'b1 && empty === 1'b0) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_unexpected actual=%0h required=no_read at %0t", data_out, $time);
            end else begin
                chk("rd_data", data_out, sb_q.pop_front());
            end
        end
    end

    task automatic check_state(input logic e_ovf, input logic e_unf);
        int n;
        logic [AW:0] diff;
        n = model_q.size();
        chk("count", count, n);
        chk("empty", empty, n == 0);
        chk("full", full, n == DEPTH);
        chk("almost_full", almost_full, n >= AF_TH);
        chk("almost_empty", almost_empty, n <= AE_TH);
        chk("overflow", overflow, e_ovf);
        chk("underflow", underflow, e_unf);
        diff = dut.wptr - dut.rptr;
        chk("ptr_diff", diff, n);
        if (n > 0) chk("head", data_out, model_q[0]);
    endtask

    // One clock of stimulus; the model decides acceptance from its own size.
    task automatic cycle(input logic w, input logic r, input logic [DW-1:0] d);
        int n;
        logic acc_w, acc_r, e_ovf, e_unf;
        write   = w;
        read    = r;
        data_in = d;
        n     = model_q.size();
        acc_w = w && (n < DEPTH);
        acc_r = r && (n > 0);
        e_ovf = w && (n == DEPTH);
        e_unf = r && (n == 0);
        if (acc_r) sb_q.push_back(model_q.pop_front());
        if (acc_w) model_q.push_back(d);
        @(posedge clk);
        #1;
        write = 1'b0;
        read  = 1'b0;
        check_state(e_ovf, e_unf);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && model_q.size() > 0; i++) cycle(1'b0, 1'b1, '0);
        chk("drained", model_q.size(), 0);
    endtask

    initial begin
        logic [DW-1:0] pat;
        int wr_done;
        logic w, r;

        rst_n   = 1'b0;
        write   = 1'b0;
        read    = 1'b0;
        data_in = '0;

        // 1. Reset
        repeat (3) @(posedge clk);
        #1;
        check_state(1'b0, 1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_state(1'b0, 1'b0);

        // 2. Fill with 17 writes, last one overflows
        for (int i = 0; i < 17; i++) cycle(1'b1, 1'b0, DW'(i));

        // 3. Drain with 17 reads, last one underflows
        for (int i = 0; i < 17; i++) cycle(1'b0, 1'b1, '0);

        // 4a. Simultaneous access at count=5
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, DW'(32'h100 + i));
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, DW'(32'h200 + i));
        // 4b. Simultaneous access when full
        for (int i = 0; i < 11; i++) cycle(1'b1, 1'b0, DW'(32'h300 + i));
        cycle(1'b1, 1'b1, 32'hDEAD_BEEF);
        // 4c. Simultaneous access when empty
        drain();
        cycle(1'b1, 1'b1, 32'h0000_0C0C);
        drain();

        // 5. Random traffic across many pointer wraps
        pat     = 32'h1000;
        wr_done = 0;
        for (int c = 0; c < 2000 && wr_done < 100; c++) begin
            w = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 2) == 0);
            if (c % 64 >= 40) r = 1'($urandom_range(0, 1));
            if (w && model_q.size() < DEPTH) begin
                cycle(1'b1, r, pat);
                pat = pat + 1;
                wr_done++;
            end else begin
                cycle(w, r, pat);
            end
        end
        chk("rand_writes", wr_done, 100);
        drain();

        // 6. Asynchronous reset in mid-operation
        for (int i = 0; i < 9; i++) cycle(1'b1, 1'b0, DW'($urandom));
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_count", count, 0);
        chk("arst_empty", empty, 1);
        chk("arst_full", full, 0);
        chk("arst_aempty", almost_empty, 1);
        chk("arst_afull", almost_full, 0);
        model_q.delete();
        sb_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle(1'b1, 1'b0, 32'h0000_00A5);
        chk("post_reset_data", data_out, 32'h0000_00A5);
        drain();

        chk("sb_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Single-clock FIFO. It is the parametrised successor to the team's small Gray-pointer CDC FIFO, for buffering inside one clock domain.
- Data width, depth and almost-full/almost-empty thresholds are set by parameters.
- Provides an occupancy count and overflow/underflow error pulses, which the CDC FIFO lacks.
- First-word-fall-through output: the head entry is visible on data_out without a read.
- Intended for stream buffering between pipeline stages and for rate smoothing ahead of CDC blocks.

Parameters:
- P_DATA_WIDTH, 32: width of each entry.
- P_ADDR_WIDTH, 4: log2 of depth. DEPTH = 2**P_ADDR_WIDTH. Legal range 1..10.
- P_AFULL_THRESH, 2**P_ADDR_WIDTH-2: almost_full asserts when count >= this value. Legal range 1..DEPTH.
- P_AEMPTY_THRESH, 1: almost_empty asserts when count <= this value. Legal range 0..DEPTH-1.

Ports:
- clk, in, 1: the single clock. All logic is on the rising edge.
- rst_n, in, 1: asynchronous, active-low reset.
- write, in, 1: write request.
- data_in, in, P_DATA_WIDTH: write data.
- full, out, 1: FIFO holds DEPTH entries.
- almost_full, out, 1: count >= P_AFULL_THRESH.
- read, in, 1: read request (pop the head entry).
- data_out, out, P_DATA_WIDTH: head entry (FWFT).
- empty, out, 1: FIFO holds 0 entries.
- almost_empty, out, 1: count <= P_AEMPTY_THRESH.
- count, out, P_ADDR_WIDTH+1: current occupancy, 0..DEPTH.
- overflow, out, 1: one-cycle pulse reporting a write attempted while full.
- underflow, out, 1: one-cycle pulse reporting a read attempted while empty.

Behaviour:
- Reset: clock is clk; reset is asynchronous, active-low, named rst_n.
  - Asserting rst_n=0 immediately clears wptr, rptr and count to 0.
  - Outputs during and after reset: empty=1, full=0, almost_full=0, almost_empty=1, overflow=0, underflow=0.
  - Deassertion is synchronised externally. The block does not reset the RAM.
- Storage: DEPTH x P_DATA_WIDTH array with no reset, written synchronously and read combinationally (distributed RAM).
- Pointers: wptr and rptr are P_ADDR_WIDTH+1-bit binary. The low P_ADDR_WIDTH bits address the RAM; the MSB is the wrap bit. Both increment modulo 2**(P_ADDR_WIDTH+1).
- Accepted events, evaluated on the flag values present before the edge:
  - wr_en = write && !full.
  - rd_en = read && !empty.
- Write: on wr_en, ram[wptr] <= data_in and wptr increments.
- Read: on rd_en, rptr increments.
- data_out: always equals ram[rptr[P_ADDR_WIDTH-1:0]].
  - Valid whenever empty=0.
  - Don't-care while empty=1.
  - A written word is visible on data_out the cycle after the write edge if the FIFO was empty.
- Count register:
  - count_next = count + wr_en - rd_en.
  - count == wptr - rptr at all times. This is the verification invariant.
- Flags: full, empty, almost_full and almost_empty are registered, computed from count_next. They change in the same cycle as count, so there is no extra latency beyond count.
  - full = (count == DEPTH).
  - empty = (count == 0).
- Simultaneous read and write:
  - Mid-occupancy: both accepted, count unchanged, flags unchanged.
  - When empty: only the write is accepted; underflow pulses.
  - When full: only the read is accepted; overflow pulses. There is no write-through or bypass.
- Errors:
  - overflow <= write && full.
  - underflow <= read && empty.
  - Each is registered, asserted for exactly the cycle after the offending edge, and never sticky.
  - A rejected access changes no pointer or RAM state.
- Wrap-around: pointer overflow past 2**(P_ADDR_WIDTH+1)-1 to 0 is seamless. Ordering is preserved indefinitely.
- Reset mid-operation: all queued data is discarded and all flags/count return to their reset values in the same cycle rst_n falls, without waiting for a clock edge.

Test Plan:
1. Reset: rst_n=0 for 3 cycles, then release with DEPTH=16 defaults -> count=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0.
2. Fill: 17 back-to-back writes of 0x00..0x10 from empty -> after the 14th write almost_full=1; after the 16th full=1, count=16; the 17th write is dropped, with overflow=1 for one cycle and count still 16.
3. Drain: 17 back-to-back reads after test 2 -> data_out sequence 0x00..0x0F in order; empty=1 after the 16th read; underflow=1 for one cycle after the 17th read; almost_empty=1 once count<=1.
4. Simultaneous access:
   - At count=5, write+read together for 10 cycles -> count stays 5, data in order, no error pulses.
   - At count=16, write+read together -> read accepted, write rejected, count=15, overflow=1.
   - At count=0, write+read together -> count=1, underflow=1, data_out equals the written word.
5. Wrap-around: 100 random-gap writes/reads of an incrementing pattern, keeping occupancy between 0 and 16 -> output sequence identical to input, and count == wptr-rptr every cycle.
6. Mid-operation reset: at count=9, assert rst_n=0 asynchronously between edges -> count=0 and empty=1 immediately; after release, the next write of 0xA5 appears on data_out with count=1.
